renderizador_entidades: RTL and testbench
=========================================

# renderizador_entidades

Pixel-side consumer of the entity coordinate bus: reads ship, enemy and ball positions and radii and paints them into the VGA stream. Coordinates are snapshotted once per frame, so objects never tear mid-frame. Each pixel is classified through a 2-stage pipeline: rectangle hit-tests for ship and enemy, squared-distance circle tests for the balls. A fixed priority then selects the output colour. Sits between the entity logic and the VGA timing generator's colour outputs.

## Interface
- LARG_NAVE, 45, ship sprite width (px)
- ALT_NAVE, 20, ship sprite height (px)
- LARG_INIMIGO, 40, enemy sprite width (px)
- ALT_INIMIGO, 20, enemy sprite height (px)
- COR_NAVE / COR_INIMIGO / COR_BOLA_ALIADA / COR_BOLA_INIMIGA / COR_FUNDO, 24'h00FF00 / 24'hFF0000 / 24'hFFFF00 / 24'hFF00FF / 24'h000000, {R,G,B} colours
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- pixel_en  in  1  pixel strobe (1 of every 2 clocks at 640x480)
- frame_start  in  1  1-clock pulse at start of vertical blank
- pausa  in  1  game paused
- px, py  in  10 each  current pixel coordinate
- ativo  in  1  pixel is in the visible area
- x_nave, y_nave, x_inimigo, y_inimigo  in  10 each  sprite top-left corners
- inimigo_vivo  in  1  enemy is drawn only when 1
- x_bola_aliada, y_bola_aliada, raio_bola_aliada  in  10 each  ally ball centre and radius
- x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga  in  10 each  enemy ball centre and radius
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- ativo_out  out  1  `ativo` delayed to align with the colour outputs

## Operation
- Snapshot: on a cycle with frame_start=1, all entity inputs and pausa are registered into shadow registers. Hit tests use shadow values only.
- frame_start and pixel_en in the same cycle: the pixel captured that cycle uses the pre-update shadow values.
- Frame counter: 6-bit, increments on each frame_start, wraps 63→0.
- Stage 1 (advances on pixel_en):
  - Register signed 11-bit dx = px − xc and dy = py − yc for each ball.
  - Register r² (20-bit unsigned) for each ball.
  - Register rectangle hits: nave hit ⇔ x_nave ≤ px < x_nave+LARG_NAVE and y_nave ≤ py < y_nave+ALT_NAVE. Bounds are computed at 11 bits, so sprites near 1023 do not wrap. Enemy hit uses the same rule and is additionally ANDed with shadow inimigo_vivo.
  - Register ativo.
- Stage 2 (advances on pixel_en):
  - Circle hit ⇔ dx²+dy² ≤ r², with the sum at 21 bits unsigned, and radius ≠ 0. Radius 0 means the ball is hidden.
  - Priority: bola_inimiga > bola_aliada > nave > inimigo > fundo.
  - Register the selected colour. Colour is forced to 0 when the delayed ativo = 0.
- Outputs change only on pixel_en cycles and hold between strobes.

## Timing
- Latency: the colour for the pixel sampled at pixel_en strobe n appears on VGA_* and ativo_out at the clock edge of strobe n+1 (2 registered stages). It is stable until strobe n+2.
- New shadow values take effect on the first pixel_en after the frame_start cycle.
- Reset values:
  - VGA_R/G/B=0, ativo_out=0.
  - All pipeline registers 0.
  - All shadow coordinates and radii 0; shadow inimigo_vivo=0, shadow pausa=0.
  - Frame counter 0.
  - Net effect: only the ship can be drawn until the first frame_start.
- Reset mid-frame: the pipeline is flushed. Outputs stay black until 2 pixel_en strobes after reset is deasserted with ativo=1.
- pixel_en=0 for any number of cycles: the pipeline freezes with no data lost.

## Configuration
- RENDER_PAUSA_PISCA_EN defined:
  - While shadow pausa=1, the ship is hidden on frames where frame_counter[4]=1. This gives a 16-frames-on / 16-frames-off blink.
  - Balls and enemy are unaffected.
- Undefined: pausa is ignored and not snapshotted; the ship is always drawn.

## Test plan
- Reset, then frame_start with nave=(100,200), others 0 and vivo=0. Pixel (100,200) ativo=1 → COR_NAVE after 2 strobes. Pixels (145,200) and (99,200) → COR_FUNDO.
- Ally ball (300,300), r=5. Pixels (305,300) and (304,303) → yellow (25 ≤ 25). Pixel (304,304) → fundo (32 > 25). r=0 → (300,300) fundo.
- Enemy at (20,40): pixel (30,50) with vivo=1 → red. With vivo=0 in the next snapshot → fundo.
- Overlap: enemy ball r=5 and ally ball both centred on the ship at (110,205) → COR_BOLA_INIMIGA. Change coords between frame_starts without a frame_start → output unchanged.
- Ship at x_nave=1000, pixel (5,…) → no hit (no wrap). Pixel inside the ship with ativo=0 → output 0, ativo_out=0.
- With RENDER_PAUSA_PISCA_EN: pausa=1 → ship pixel visible for frames 0–15, black for 16–31. With pausa=0 → always visible.

Source files
------------

// File: rtl/renderizador_entidades.sv
// Entity renderer: snapshots entity coordinates once per frame and classifies each pixel in a 2-stage pipeline.
// Optional macro RENDER_PAUSA_PISCA_EN: blinks the ship (16 frames on / 16 off) while the game is paused.
module renderizador_entidades #(
    parameter int          LARG_NAVE        = 45,
    parameter int          ALT_NAVE         = 20,
    parameter int          LARG_INIMIGO     = 40,
    parameter int          ALT_INIMIGO      = 20,
    parameter logic [23:0] COR_NAVE         = 24'h00FF00,
    parameter logic [23:0] COR_INIMIGO      = 24'hFF0000,
    parameter logic [23:0] COR_BOLA_ALIADA  = 24'hFFFF00,
    parameter logic [23:0] COR_BOLA_INIMIGA = 24'hFF00FF,
    parameter logic [23:0] COR_FUNDO        = 24'h000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pixel_en,
    input  logic       frame_start,
    input  logic       pausa,
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic       ativo,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic [9:0] x_inimigo,
    input  logic [9:0] y_inimigo,
    input  logic       inimigo_vivo,
    input  logic [9:0] x_bola_aliada,
    input  logic [9:0] y_bola_aliada,
    input  logic [9:0] raio_bola_aliada,
    input  logic [9:0] x_bola_inimiga,
    input  logic [9:0] y_bola_inimiga,
    input  logic [9:0] raio_bola_inimiga,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       ativo_out
);

    function automatic logic [9:0] absVal(input logic signed [10:0] v);
        return 10'(v[10] ? -v : v);
    endfunction

    function automatic logic [19:0] sq(input logic [9:0] a);
        return {10'b0, a} * {10'b0, a};
    endfunction

    // Bounds are widened to 11 bits so sprites near the right/bottom edge never wrap to 0.
    function automatic logic inRect(input logic [9:0] p, input logic [9:0] q,
                                    input logic [9:0] x0, input logic [9:0] y0,
                                    input logic [10:0] w, input logic [10:0] h);
        return ({1'b0, x0} <= {1'b0, p}) && ({1'b0, p} < ({1'b0, x0} + w)) &&
               ({1'b0, y0} <= {1'b0, q}) && ({1'b0, q} < ({1'b0, y0} + h));
    endfunction

    logic [9:0] xNave_q, yNave_q, xInim_q, yInim_q;
    logic [9:0] xBolaAli_q, yBolaAli_q, rBolaAli_q;
    logic [9:0] xBolaIni_q, yBolaIni_q, rBolaIni_q;
    logic       vivo_q;
    logic [5:0] frameCnt_q;
    logic       pausa_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            xNave_q    <= '0;
            yNave_q    <= '0;
            xInim_q    <= '0;
            yInim_q    <= '0;
            xBolaAli_q <= '0;
            yBolaAli_q <= '0;
            rBolaAli_q <= '0;
            xBolaIni_q <= '0;
            yBolaIni_q <= '0;
            rBolaIni_q <= '0;
            vivo_q     <= 1'b0;
            frameCnt_q <= '0;
        end else if (frame_start) begin
            xNave_q    <= x_nave;
            yNave_q    <= y_nave;
            xInim_q    <= x_inimigo;
            yInim_q    <= y_inimigo;
            xBolaAli_q <= x_bola_aliada;
            yBolaAli_q <= y_bola_aliada;
            rBolaAli_q <= raio_bola_aliada;
            xBolaIni_q <= x_bola_inimiga;
            yBolaIni_q <= y_bola_inimiga;
            rBolaIni_q <= raio_bola_inimiga;
            vivo_q     <= inimigo_vivo;
            frameCnt_q <= frameCnt_q + 6'd1;
        end
    end

`ifdef RENDER_PAUSA_PISCA_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            pausa_q <= 1'b0;
        else if (frame_start)
            pausa_q <= pausa;
    end
`else
    logic unusedPausa;
    assign pausa_q     = 1'b0;
    assign unusedPausa = ^{pausa, pausa_q, frameCnt_q};
`endif

    logic                naveVisivel;
    logic                hitNave_d, hitInim_d, ativo1_d;
    logic signed [10:0]  dxAli_d, dyAli_d, dxIni_d, dyIni_d;
    logic [19:0]         r2Ali_d, r2Ini_d;

    always_comb begin
        naveVisivel = 1'b1;
`ifdef RENDER_PAUSA_PISCA_EN
        if (pausa_q && frameCnt_q[4])
            naveVisivel = 1'b0;
`endif
        hitNave_d = naveVisivel &&
                    inRect(px, py, xNave_q, yNave_q, 11'(LARG_NAVE), 11'(ALT_NAVE));
        hitInim_d = vivo_q &&
                    inRect(px, py, xInim_q, yInim_q, 11'(LARG_INIMIGO), 11'(ALT_INIMIGO));
        dxAli_d   = $signed({1'b0, px}) - $signed({1'b0, xBolaAli_q});
        dyAli_d   = $signed({1'b0, py}) - $signed({1'b0, yBolaAli_q});
        dxIni_d   = $signed({1'b0, px}) - $signed({1'b0, xBolaIni_q});
        dyIni_d   = $signed({1'b0, py}) - $signed({1'b0, yBolaIni_q});
        r2Ali_d   = sq(rBolaAli_q);
        r2Ini_d   = sq(rBolaIni_q);
        ativo1_d  = ativo;
    end

    logic                hitNave_q, hitInim_q, ativo1_q;
    logic signed [10:0]  dxAli_q, dyAli_q, dxIni_q, dyIni_q;
    logic [19:0]         r2Ali_q, r2Ini_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hitNave_q <= 1'b0;
            hitInim_q <= 1'b0;
            ativo1_q  <= 1'b0;
            dxAli_q   <= '0;
            dyAli_q   <= '0;
            dxIni_q   <= '0;
            dyIni_q   <= '0;
            r2Ali_q   <= '0;
            r2Ini_q   <= '0;
        end else if (pixel_en) begin
            hitNave_q <= hitNave_d;
            hitInim_q <= hitInim_d;
            ativo1_q  <= ativo1_d;
            dxAli_q   <= dxAli_d;
            dyAli_q   <= dyAli_d;
            dxIni_q   <= dxIni_d;
            dyIni_q   <= dyIni_d;
            r2Ali_q   <= r2Ali_d;
            r2Ini_q   <= r2Ini_d;
        end
    end

    logic [20:0] distAli, distIni;
    logic        hitBolaAli, hitBolaIni;
    logic [23:0] cor_d;

    // A zero radius means the ball is hidden, so it never hits even at its own centre.
    always_comb begin
        distAli    = {1'b0, sq(absVal(dxAli_q))} + {1'b0, sq(absVal(dyAli_q))};
        distIni    = {1'b0, sq(absVal(dxIni_q))} + {1'b0, sq(absVal(dyIni_q))};
        hitBolaAli = (r2Ali_q != 20'd0) && (distAli <= {1'b0, r2Ali_q});
        hitBolaIni = (r2Ini_q != 20'd0) && (distIni <= {1'b0, r2Ini_q});
        cor_d      = COR_FUNDO;
        if (hitBolaIni)
            cor_d = COR_BOLA_INIMIGA;
        else if (hitBolaAli)
            cor_d = COR_BOLA_ALIADA;
        else if (hitNave_q)
            cor_d = COR_NAVE;
        else if (hitInim_q)
            cor_d = COR_INIMIGO;
        if (!ativo1_q)
            cor_d = 24'h000000;
    end

    logic [23:0] cor_q;
    logic        ativoOut_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cor_q      <= '0;
            ativoOut_q <= 1'b0;
        end else if (pixel_en) begin
            cor_q      <= cor_d;
            ativoOut_q <= ativo1_q;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = cor_q;
    assign ativo_out             = ativoOut_q;

endmodule

// File: tb/tb_renderizador_entidades.sv
// Self-checking bench for renderizador_entidades: directed steps from the test plan plus randomized frames,
// compared against a geometric reference model of the snapshotted scene.
module tb_renderizador_entidades;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0, pixel_en = 1'b0, frame_start = 1'b0, pausa = 1'b0, ativo = 1'b0;
    logic [9:0] px = '0, py = '0;
    logic [9:0] x_nave = '0, y_nave = '0, x_inimigo = '0, y_inimigo = '0;
    logic       inimigo_vivo = 1'b0;
    logic [9:0] x_bola_aliada = '0, y_bola_aliada = '0, raio_bola_aliada = '0;
    logic [9:0] x_bola_inimiga = '0, y_bola_inimiga = '0, raio_bola_inimiga = '0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       ativo_out;

    renderizador_entidades dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .pixel_en(pixel_en), .frame_start(frame_start),
        .pausa(pausa), .px(px), .py(py), .ativo(ativo),
        .x_nave(x_nave), .y_nave(y_nave), .x_inimigo(x_inimigo), .y_inimigo(y_inimigo),
        .inimigo_vivo(inimigo_vivo),
        .x_bola_aliada(x_bola_aliada), .y_bola_aliada(y_bola_aliada), .raio_bola_aliada(raio_bola_aliada),
        .x_bola_inimiga(x_bola_inimiga), .y_bola_inimiga(y_bola_inimiga), .raio_bola_inimiga(raio_bola_inimiga),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .ativo_out(ativo_out)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int xN, yN, xI, yI, xA, yA, rA, xE, yE, rE;
        bit vivo, pausa;
    } scene_t;

    scene_t      sh;
    int          frames = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [23:0] shownCol = '0, pendCol = '0;
    logic        shownAtv = 1'b0, pendAtv = 1'b0;

    function automatic bit inCircle(int x, int y, int cx, int cy, int r);
        return (r != 0) && ((x - cx) * (x - cx) + (y - cy) * (y - cy) <= r * r);
    endfunction

    function automatic bit inBox(int x, int y, int x0, int y0, int w, int h);
        return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
    endfunction

    // What the scene should look like at (x,y), painted from the most to least important object.
    function automatic logic [23:0] refColour(int x, int y, bit a);
        bit shipOn;
        shipOn = 1'b1;
`ifdef RENDER_PAUSA_PISCA_EN
        if (sh.pausa && ((frames / 16) % 2 == 1)) shipOn = 1'b0;
`endif
        if (!a) return 24'h000000;
        if (inCircle(x, y, sh.xE, sh.yE, sh.rE)) return 24'hFF00FF;
        if (inCircle(x, y, sh.xA, sh.yA, sh.rA)) return 24'hFFFF00;
        if (shipOn && inBox(x, y, sh.xN, sh.yN, 45, 20)) return 24'h00FF00;
        if (sh.vivo && inBox(x, y, sh.xI, sh.yI, 40, 20)) return 24'hFF0000;
        return 24'h000000;
    endfunction

    function automatic void snapshot();
        sh.xN = int'(x_nave);          sh.yN = int'(y_nave);
        sh.xI = int'(x_inimigo);       sh.yI = int'(y_inimigo);
        sh.xA = int'(x_bola_aliada);   sh.yA = int'(y_bola_aliada);   sh.rA = int'(raio_bola_aliada);
        sh.xE = int'(x_bola_inimiga);  sh.yE = int'(y_bola_inimiga);  sh.rE = int'(raio_bola_inimiga);
        sh.vivo  = inimigo_vivo;
        sh.pausa = pausa;
        frames   = (frames + 1) % 64;
    endfunction

    task automatic checkOutput(input string tag);
        vectors++;
        assert ({VGA_R, VGA_G, VGA_B} === shownCol) else begin
            miscompares++;
            $error("[TB] FAIL %s colour: observed %h expected %h", tag, {VGA_R, VGA_G, VGA_B}, shownCol);
        end
        vectors++;
        assert (ativo_out === shownAtv) else begin
            miscompares++;
            $error("[TB] FAIL %s ativo_out: observed %b expected %b", tag, ativo_out, shownAtv);
        end
    endtask

    // One pixel strobe; the outputs after this edge belong to the previous strobe's pixel.
    task automatic applyStimulus(input int x, input int y, input bit a, input bit withFrame);
        logic [23:0] e;
        @(negedge CLOCK_50);
        px = 10'(x);
        py = 10'(y);
        ativo = a;
        pixel_en = 1'b1;
        frame_start = withFrame;
        e = refColour(x, y, a);
        if (withFrame) snapshot();
        @(posedge CLOCK_50);
        #1;
        pixel_en = 1'b0;
        frame_start = 1'b0;
        shownCol = pendCol;
        shownAtv = pendAtv;
        checkOutput("pixel");
        pendCol = e;
        pendAtv = a;
    endtask

    task automatic frameStart();
        @(negedge CLOCK_50);
        frame_start = 1'b1;
        snapshot();
        @(posedge CLOCK_50);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge CLOCK_50);
        reset = 1'b1;
        pixel_en = 1'b0;
        frame_start = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        sh = '{default: 0};
        frames = 0;
        shownCol = '0;
        shownAtv = 1'b0;
        pendCol = '0;
        pendAtv = 1'b0;
        checkOutput("reset");
        reset = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checkOutput("hold");
    endtask

    initial begin
        int base;
        int x;
        int y;
        sh = '{default: 0};

        resetDut();
        // Before any snapshot the ship sits at the origin.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(44, 19, 1, 0);
        applyStimulus(45, 0, 1, 0);

        x_nave = 10'd100; y_nave = 10'd200;
        frameStart();
        applyStimulus(100, 200, 1, 0);
        applyStimulus(145, 200, 1, 0);
        applyStimulus(99, 200, 1, 0);
        applyStimulus(144, 219, 1, 0);
        applyStimulus(100, 220, 1, 0);

        x_bola_aliada = 10'd300; y_bola_aliada = 10'd300; raio_bola_aliada = 10'd5;
        frameStart();
        applyStimulus(305, 300, 1, 0);
        applyStimulus(304, 303, 1, 0);
        applyStimulus(304, 304, 1, 0);
        applyStimulus(296, 297, 1, 0);
        raio_bola_aliada = 10'd0;
        frameStart();
        applyStimulus(300, 300, 1, 0);

        x_inimigo = 10'd20; y_inimigo = 10'd40; inimigo_vivo = 1'b1;
        frameStart();
        applyStimulus(30, 50, 1, 0);
        applyStimulus(59, 59, 1, 0);
        applyStimulus(60, 50, 1, 0);
        inimigo_vivo = 1'b0;
        frameStart();
        applyStimulus(30, 50, 1, 0);

        x_bola_inimiga = 10'd110; y_bola_inimiga = 10'd205; raio_bola_inimiga = 10'd5;
        x_bola_aliada = 10'd110; y_bola_aliada = 10'd205; raio_bola_aliada = 10'd5;
        frameStart();
        applyStimulus(110, 205, 1, 0);
        applyStimulus(120, 205, 1, 0);
        x_bola_inimiga = 10'd500; x_nave = 10'd600;
        applyStimulus(110, 205, 1, 0);
        applyStimulus(120, 205, 1, 0);

        x_nave = 10'd1000; y_nave = 10'd200;
        raio_bola_inimiga = 10'd0; raio_bola_aliada = 10'd0;
        frameStart();
        applyStimulus(5, 200, 1, 0);
        applyStimulus(1000, 200, 1, 0);
        applyStimulus(1023, 219, 1, 0);
        applyStimulus(1010, 205, 0, 0);

        // Snapshot and strobe together: that pixel still sees the old ship position.
        x_nave = 10'd50;
        applyStimulus(1005, 205, 1, 1);
        applyStimulus(1005, 205, 1, 0);
        applyStimulus(55, 205, 1, 0);
        idleCycles(5);

        applyStimulus(55, 205, 1, 0);
        resetDut();
        applyStimulus(10, 10, 1, 0);
        applyStimulus(10, 10, 1, 0);

        x_nave = 10'd200; y_nave = 10'd100; pausa = 1'b1;
        for (int f = 0; f < 34; f++) begin
            frameStart();
            applyStimulus(210, 110, 1, 0);
        end
        pausa = 1'b0;
        for (int f = 0; f < 18; f++) begin
            frameStart();
            applyStimulus(210, 110, 1, 0);
        end

        for (int f = 0; f < 24; f++) begin
            base = int'($urandom_range(0, 960));
            x_nave            = 10'(base + int'($urandom_range(0, 60)));
            y_nave            = 10'(base + int'($urandom_range(0, 60)));
            x_inimigo         = 10'(base + int'($urandom_range(0, 60)));
            y_inimigo         = 10'(base + int'($urandom_range(0, 60)));
            inimigo_vivo      = 1'($urandom_range(0, 1));
            x_bola_aliada     = 10'(base + int'($urandom_range(0, 60)));
            y_bola_aliada     = 10'(base + int'($urandom_range(0, 60)));
            raio_bola_aliada  = 10'($urandom_range(0, 25));
            x_bola_inimiga    = 10'(base + int'($urandom_range(0, 60)));
            y_bola_inimiga    = 10'(base + int'($urandom_range(0, 60)));
            raio_bola_inimiga = 10'($urandom_range(0, 25));
            pausa             = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                applyStimulus(base, base, 1, 1);
            else
                frameStart();
            for (int p = 0; p < 30; p++) begin
                if ($urandom_range(0, 7) == 0) begin
                    x = int'($urandom_range(0, 1023));
                    y = int'($urandom_range(0, 1023));
                end else begin
                    x = base + int'($urandom_range(0, 110));
                    y = base + int'($urandom_range(0, 90));
                    if (x > 1023) x = 1023;
                    if (y > 1023) y = 1023;
                end
                repeat ($urandom_range(0, 2)) @(posedge CLOCK_50);
                applyStimulus(x, y, 1'($urandom_range(0, 7) != 0), 0);
            end
        end

        applyStimulus(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
